pa_spsram_64x44_ctrl: RTL and testbench
=======================================

// Module: pa_spsram_64x44_ctrl
// PURPOSE
//  Initiator/controller for the 64x44 single-port SRAM macro. Clears the array after reset,
//  then accepts read/write requests on a valid/ready port and drives the SRAM pins
//  (active-low CEN/GWEN/WEN). Read data returns in order on a valid/ready response port.
//  A response FIFO absorbs the fixed 1-cycle SRAM read latency under backpressure.
//  Sits between LSU request logic and the pa_spsram_64x44 instance.
// PARAMETERS
//  ADDR_WIDTH  6   SRAM address width; DEPTH = 2**ADDR_WIDTH = 64
//  DATA_WIDTH  44  SRAM data / bit-write-enable width
//  RSP_DEPTH   3   response FIFO entries; 3 sustains one read per cycle
//  INIT_VAL    0   word written to every entry during INIT
// PORTS
//  forever_cpuclk  in   1           clock; the only clock
//  cpurst          in   1           synchronous active-high reset
//  req_vld         in   1           request valid
//  req_rdy         out  1           request ready
//  req_wr          in   1           1=write, 0=read
//  req_addr        in   ADDR_WIDTH  entry index
//  req_wdata       in   DATA_WIDTH  write data
//  req_wmask       in   DATA_WIDTH  per-bit write enable, active-high
//  rsp_vld         out  1           read data valid
//  rsp_rdy         in   1           read data accepted
//  rsp_rdata       out  DATA_WIDTH  read data, FIFO head
//  init_done       out  1           array cleared; requests may be issued
//  ram_a           out  ADDR_WIDTH  SRAM A
//  ram_cen         out  1           SRAM CEN, active-low
//  ram_gwen        out  1           SRAM GWEN, active-low (0=write)
//  ram_wen         out  DATA_WIDTH  SRAM WEN, active-low per bit
//  ram_d           out  DATA_WIDTH  SRAM D
//  ram_q           in   DATA_WIDTH  SRAM Q, valid the cycle after a read access
// BEHAVIOUR
//  - Clock/reset: one clock, forever_cpuclk. Reset cpurst is synchronous and active-high.
//  - Reset values (cycle cpurst=1 and the edge after it):
//    - req_rdy=0, rsp_vld=0, init_done=0.
//    - ram_cen=1, ram_gwen=1, ram_wen=all 1s, ram_a=0, ram_d=0.
//    - FIFO storage and rsp_rdata are 0. FSM is in INIT with init_cnt=0.
//  - FSM INIT:
//    - Each cycle: ram_a=init_cnt, ram_cen=0, ram_gwen=0, ram_wen=0, ram_d=INIT_VAL.
//    - init_cnt increments each cycle. After the write at cnt=63 (wrap) -> ACTIVE.
//    - Takes exactly 64 cycles. req_rdy=0 throughout.
//  - FSM ACTIVE:
//    - init_done=1 (registered; high the first ACTIVE cycle).
//    - No return to INIT except via cpurst.
//  - Credit rule: req_rdy = ACTIVE && (fifo_cnt + rd_inflight) < RSP_DEPTH.
//    - req_rdy is registered-state only; it does not depend on req_* or rsp_rdy.
//    - Writes also wait on credit.
//  - Accept (req_vld&&req_rdy): SRAM pins are driven combinationally the same cycle.
//    - ram_cen=0, ram_a=req_addr, ram_d=req_wdata.
//    - Write: ram_gwen=0, ram_wen=~req_wmask.
//    - Read: ram_gwen=1, ram_wen=all 1s.
//  - No accept: ram_cen=1, ram_gwen=1, ram_wen=all 1s, ram_a=0, ram_d=0.
//  - Writes produce no response. A write with mask 0 is still issued and changes no bits.
//  - Read pipeline:
//    - rd_inflight is set on the cycle after a read accept.
//    - During that cycle ram_q is pushed into the FIFO.
//    - rsp_vld is high the following cycle: accept->rsp_vld latency 2 cycles.
//  - FIFO: in order. Pop on rsp_vld&&rsp_rdy.
//    - Push and pop in the same cycle keep fifo_cnt unchanged.
//    - rsp_rdata is stable while rsp_vld=1 && rsp_rdy=0.
//    - The credit rule guarantees no overflow; a push when full is a design error (assertion).
//  - Ordering: a read to address X accepted the cycle after a write to X returns the new data.
//  - Reset mid-operation (cpurst=1 in any state):
//    - In-flight read data is discarded; FIFO is flushed; rsp_vld=0 next cycle.
//    - INIT restarts at address 0.
// TESTING
//  1. Release reset -> 64 cycles of ram_cen=0/ram_gwen=0, ram_a 0..63, ram_d=0.
//     init_done=1 and req_rdy=1 on cycle 65; req_rdy=0 before that.
//  2. Write addr 5 data 44'hABC, mask all 1s, then read addr 5 ->
//     rsp_vld with 44'hABC exactly 2 cycles after the read accept.
//  3. Write addr 7 = all 1s, then write addr 7 = 0 with mask 44'hF, then read addr 7 ->
//     44'hFFF_FFFF_FFF0.
//  4. 10 back-to-back reads of addr 0..9 with rsp_rdy=1 ->
//     req_rdy never drops; 10 responses on consecutive cycles, in order.
//  5. rsp_rdy=0, issue reads ->
//     3 accepted, then req_rdy=0; head data stable.
//     Raise rsp_rdy -> 3 responses drain in order, then req_rdy=1.
//  6. cpurst pulse while rsp_vld=1 and a read is in flight ->
//     next cycle rsp_vld=0, req_rdy=0, ram_a=0 INIT write; no stale response after init_done.

Source files
------------

// File: rtl/pa_spsram_64x44_ctrl_if.sv
// Request/response port between LSU request logic and the 64x44 SRAM controller.
// The LSU side is the master, and the controller side is the slave.
interface pa_spsram_64x44_ctrl_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 44
);
   logic                  req_vld;
   logic                  req_rdy;
   logic                  req_wr;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [DATA_WIDTH-1:0] req_wmask;
   logic                  rsp_vld;
   logic                  rsp_rdy;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_rdata
   );

   modport slave (
      input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
      output req_rdy, rsp_vld, rsp_rdata
   );
endinterface

// File: rtl/pa_spsram_64x44_ctrl.sv
// Controller for the 64x44 single-port SRAM macro. After reset it clears the array.
// It then serves in-order reads and writes, using a credit-protected response FIFO.

module pa_spsram_64x44_ctrl_chk #(
   parameter int CNT_W     = 2,
   parameter int RSP_DEPTH = 3
) (
   input logic             clk_i,
   input logic             rst_i,
   input logic             push_i,
   input logic [CNT_W-1:0] cnt_i
);
   // A push into a full response FIFO means the credit accounting is broken
   assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && (cnt_i == CNT_W'(RSP_DEPTH))));
endmodule

module pa_spsram_64x44_ctrl #(
   parameter int                    ADDR_WIDTH = 6,
   parameter int                    DATA_WIDTH = 44,
   parameter int                    RSP_DEPTH  = 3,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL   = {DATA_WIDTH{1'b0}}
) (
   input  logic                    forever_cpuclk,
   input  logic                    cpurst,
   pa_spsram_64x44_ctrl_if.slave   lsu,
   output logic                    init_done,
   output logic [ADDR_WIDTH-1:0]   ram_a,
   output logic                    ram_cen,
   output logic                    ram_gwen,
   output logic [DATA_WIDTH-1:0]   ram_wen,
   output logic [DATA_WIDTH-1:0]   ram_d,
   input  logic [DATA_WIDTH-1:0]   ram_q
);
   localparam int               PTR_W      = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int               CNT_W      = $clog2(RSP_DEPTH + 1);
   localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(RSP_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RSP_DEPTH - 1);

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_ACTIVE = 1'b1} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic                  init_done_q, init_done_d;
   logic                  rd_inflight_q, rd_inflight_d;
   logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  req_rdy_s, acc_s, push_s, pop_s, rsp_vld_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1'b1);
   endfunction

   // Credit counts both queued data and the read whose data arrives this cycle
   assign req_rdy_s = !cpurst && (state_q == ST_ACTIVE) &&
                      (({1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_inflight_q}) < CREDIT_MAX);
   assign acc_s         = lsu.req_vld && req_rdy_s;
   assign rd_inflight_d = acc_s && !lsu.req_wr;
   assign push_s        = rd_inflight_q;
   assign rsp_vld_s     = !cpurst && (cnt_q != {CNT_W{1'b0}});
   assign pop_s         = rsp_vld_s && lsu.rsp_rdy;

   assign lsu.req_rdy   = req_rdy_s;
   assign lsu.rsp_vld   = rsp_vld_s;
   assign lsu.rsp_rdata = fifo_q[rd_ptr_q];
   assign init_done     = !cpurst && init_done_q;

   // FSM state register
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= {ADDR_WIDTH{1'b0}};
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   // FSM next state: sweep every address once, then stay active until reset
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1'b1);
            if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
               state_d     = ST_ACTIVE;
               init_done_d = 1'b1;
            end else begin
               state_d     = ST_INIT;
            end
         end
         ST_ACTIVE: begin
            state_d = ST_ACTIVE;
         end
         default: begin
            state_d     = ST_INIT;
            init_cnt_d  = {ADDR_WIDTH{1'b0}};
            init_done_d = 1'b0;
         end
      endcase
   end

   // SRAM pins: clear sweep during INIT, otherwise the accepted request passes through
   always_comb begin
      ram_cen  = 1'b1;
      ram_gwen = 1'b1;
      ram_wen  = {DATA_WIDTH{1'b1}};
      ram_a    = {ADDR_WIDTH{1'b0}};
      ram_d    = {DATA_WIDTH{1'b0}};
      if (cpurst) begin
         ram_cen = 1'b1;
      end else if (state_q == ST_INIT) begin
         ram_cen  = 1'b0;
         ram_gwen = 1'b0;
         ram_wen  = {DATA_WIDTH{1'b0}};
         ram_a    = init_cnt_q;
         ram_d    = INIT_VAL;
      end else if (acc_s) begin
         ram_cen = 1'b0;
         ram_a   = lsu.req_addr;
         ram_d   = lsu.req_wdata;
         if (lsu.req_wr) begin
            ram_gwen = 1'b0;
            ram_wen  = ~lsu.req_wmask;
         end else begin
            ram_gwen = 1'b1;
            ram_wen  = {DATA_WIDTH{1'b1}};
         end
      end else begin
         ram_cen = 1'b1;
      end
   end

   // Read pipeline and response FIFO; reset drops in-flight and queued data
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         rd_inflight_q <= 1'b0;
         wr_ptr_q      <= {PTR_W{1'b0}};
         rd_ptr_q      <= {PTR_W{1'b0}};
         cnt_q         <= {CNT_W{1'b0}};
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         rd_inflight_q <= rd_inflight_d;
         if (push_s) begin
            fifo_q[wr_ptr_q] <= ram_q;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop_s) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1'b1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1'b1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   pa_spsram_64x44_ctrl_chk #(.CNT_W(CNT_W), .RSP_DEPTH(RSP_DEPTH)) u_chk (
      .clk_i  (forever_cpuclk),
      .rst_i  (cpurst),
      .push_i (push_s),
      .cnt_i  (cnt_q)
   );
endmodule

// File: tb/tb_pa_spsram_64x44_ctrl.sv
// Bench for pa_spsram_64x44_ctrl. It contains a macro model on the SRAM pins and a
// transaction-level reference that is compared every cycle, plus directed scenarios.
`timescale 1ns/1ps
module tb_pa_spsram_64x44_ctrl;
   localparam int AW    = 6;
   localparam int DW    = 44;
   localparam int DEPTH = 64;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_done, ram_cen, ram_gwen;
   logic [AW-1:0] ram_a;
   logic [DW-1:0] ram_wen, ram_d;
   logic [DW-1:0] ram_q = '0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int last_acc = -1;

   pa_spsram_64x44_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) lsu_if ();

   pa_spsram_64x44_ctrl dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .lsu            (lsu_if),
      .init_done      (init_done),
      .ram_a          (ram_a),
      .ram_cen        (ram_cen),
      .ram_gwen       (ram_gwen),
      .ram_wen        (ram_wen),
      .ram_d          (ram_d),
      .ram_q          (ram_q)
   );

   always #5 clk = ~clk;

   // SRAM macro: never-written words read back as junk so a missing clear shows up
   bit [DW-1:0] sram [DEPTH];
   bit          sram_wr [DEPTH];
   always @(posedge clk) begin
      if (!ram_cen) begin
         if (!ram_gwen) begin
            sram[ram_a]    <= (sram_wr[ram_a] ? sram[ram_a] : 44'hDEA_DBEE_FBAD) & ram_wen
                              | (ram_d & ~ram_wen);
            sram_wr[ram_a] <= 1'b1;
         end else begin
            ram_q <= sram_wr[ram_a] ? sram[ram_a] : 44'hDEA_DBEE_FBAD;
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: memory image, outstanding reads with their visibility cycle, init age
   logic [DW-1:0] mem_m [DEPTH];
   ent_t          m_q [$];
   ent_t          rsp_log [$];
   int            m_age = 0;
   logic          m_active, e_rdy, e_vld, m_acc;
   logic [AW-1:0] e_a;
   logic          e_cen, e_gwen;
   logic [DW-1:0] e_wen, e_d;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_rdy", lsu_if.req_rdy, 0);
         check("rst_vld", lsu_if.rsp_vld, 0);
         check("rst_init_done", init_done, 0);
         check("rst_pins", {ram_cen, ram_gwen, ram_wen, ram_a, ram_d},
               {1'b1, 1'b1, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}});
         m_q.delete();
         m_age = 0;
      end else begin
         m_active = (m_age >= DEPTH);
         e_rdy    = m_active && (m_q.size() < 3);
         e_vld    = (m_q.size() > 0) && (m_q[0].cyc <= cyc);
         m_acc    = lsu_if.req_vld && e_rdy;
         check("req_rdy", lsu_if.req_rdy, e_rdy);
         check("rsp_vld", lsu_if.rsp_vld, e_vld);
         check("init_done", init_done, m_active);
         if (e_vld) check("rsp_rdata", lsu_if.rsp_rdata, m_q[0].data);
         e_cen = 1'b1; e_gwen = 1'b1; e_wen = '1; e_a = '0; e_d = '0;
         if (!m_active) begin
            e_cen = 1'b0; e_gwen = 1'b0; e_wen = '0; e_a = AW'(m_age); e_d = '0;
            mem_m[m_age] = '0;
         end else if (m_acc) begin
            e_cen = 1'b0; e_a = lsu_if.req_addr; e_d = lsu_if.req_wdata;
            if (lsu_if.req_wr) begin
               e_gwen = 1'b0; e_wen = ~lsu_if.req_wmask;
               mem_m[e_a] = (mem_m[e_a] & ~lsu_if.req_wmask) | (lsu_if.req_wdata & lsu_if.req_wmask);
            end else begin
               m_q.push_back('{data: mem_m[e_a], cyc: cyc + 2});
            end
         end
         check("ram_pins", {ram_cen, ram_gwen, ram_wen, ram_a, ram_d},
               {e_cen, e_gwen, e_wen, e_a, e_d});
         if (e_vld && lsu_if.rsp_rdy) void'(m_q.pop_front());
         if (lsu_if.rsp_vld && lsu_if.rsp_rdy)
            rsp_log.push_back('{data: lsu_if.rsp_rdata, cyc: cyc});
         if (m_age < DEPTH) m_age++;
      end
      if (lsu_if.req_vld && lsu_if.req_rdy) last_acc = cyc;
      cyc++;
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge
   task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] m, output int acc_cyc);
      int n = 0;
      lsu_if.req_vld = 1'b1; lsu_if.req_wr = wr; lsu_if.req_addr = a;
      lsu_if.req_wdata = d; lsu_if.req_wmask = m;
      @(negedge clk);
      while (!lsu_if.req_rdy && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) check("req_timeout", 1, 0);
      @(posedge clk); #1;
      acc_cyc = last_acc;
      lsu_if.req_vld = 1'b0;
   endtask

   task automatic wait_rsp(input int base, output logic [DW-1:0] d, output int c);
      int n = 0;
      while (rsp_log.size() <= base && n < 50) begin @(posedge clk); n++; end
      if (rsp_log.size() <= base) begin
         check("rsp_timeout", 1, 0);
         d = '0; c = -1;
      end else begin
         d = rsp_log[base].data; c = rsp_log[base].cyc;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int            acc, rc, n, base, acc_n;
      logic          took;
      logic [DW-1:0] rd, h0;
      rst = 1'b1;
      lsu_if.req_vld = 1'b0; lsu_if.req_wr = 1'b0; lsu_if.req_addr = '0;
      lsu_if.req_wdata = '0; lsu_if.req_wmask = '0; lsu_if.rsp_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 1: clear sweep length and first/after-reset values
      @(negedge clk);
      check("init_first_a", ram_a, 0);
      check("init_first_we", {ram_cen, ram_gwen}, 2'b00);
      check("reset_rdata", lsu_if.rsp_rdata, 0);
      n = 0;
      while (!lsu_if.req_rdy && n < 100) begin n++; @(negedge clk); end
      check("init_len", n, 64);
      check("init_done_c65", init_done, 1);
      @(posedge clk); #1;

      // 2: write then read, 2-cycle latency
      base = rsp_log.size();
      do_req(1'b1, 6'd5, 44'hABC, {DW{1'b1}}, acc);
      do_req(1'b0, 6'd5, 44'h0, 44'h0, acc);
      wait_rsp(base, rd, rc);
      check("t2_data", rd, 44'hABC);
      check("t2_latency", rc - acc, 2);

      // 3: partial-mask write
      base = rsp_log.size();
      do_req(1'b1, 6'd7, {DW{1'b1}}, {DW{1'b1}}, acc);
      do_req(1'b1, 6'd7, 44'h0, 44'hF, acc);
      do_req(1'b0, 6'd7, 44'h0, 44'h0, acc);
      wait_rsp(base, rd, rc);
      check("t3_data", rd, 44'hFFF_FFFF_FFF0);

      // 4: ten back-to-back reads
      for (int i = 0; i < 10; i++) do_req(1'b1, AW'(i), 44'h100 + DW'(i), {DW{1'b1}}, acc);
      base = rsp_log.size();
      lsu_if.req_vld = 1'b1; lsu_if.req_wr = 1'b0;
      for (int i = 0; i < 10; i++) begin
         lsu_if.req_addr = AW'(i);
         @(negedge clk);
         check("t4_rdy", lsu_if.req_rdy, 1);
         @(posedge clk); #1;
      end
      lsu_if.req_vld = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("t4_count", rsp_log.size() - base, 10);
      if (rsp_log.size() - base == 10) begin
         for (int i = 0; i < 10; i++) begin
            check("t4_data", rsp_log[base + i].data, 44'h100 + DW'(i));
            check("t4_consec", rsp_log[base + i].cyc - rsp_log[base].cyc, i);
         end
      end

      // 5: backpressure fills three credits, head holds, then drains
      base = rsp_log.size();
      lsu_if.rsp_rdy = 1'b0;
      lsu_if.req_vld = 1'b1; lsu_if.req_wr = 1'b0; lsu_if.req_addr = 6'd0;
      acc_n = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         took = lsu_if.req_rdy;
         if (took) acc_n++;
         @(posedge clk); #1;
         if (took) lsu_if.req_addr = lsu_if.req_addr + 6'd1;
      end
      lsu_if.req_vld = 1'b0;
      check("t5_accepts", acc_n, 3);
      @(negedge clk);
      check("t5_rdy_low", lsu_if.req_rdy, 0);
      check("t5_vld", lsu_if.rsp_vld, 1);
      h0 = lsu_if.rsp_rdata;
      check("t5_head", h0, 44'h100);
      repeat (3) @(negedge clk);
      check("t5_stable", lsu_if.rsp_rdata, h0);
      @(posedge clk); #1;
      lsu_if.rsp_rdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t5_drained", rsp_log.size() - base, 3);
      if (rsp_log.size() - base == 3) begin
         for (int i = 0; i < 3; i++) check("t5_order", rsp_log[base + i].data, 44'h100 + DW'(i));
      end
      check("t5_rdy_back", lsu_if.req_rdy, 1);

      // 6: reset with data queued and a read in flight
      lsu_if.rsp_rdy = 1'b0;
      do_req(1'b0, 6'd3, 44'h0, 44'h0, acc);
      do_req(1'b0, 6'd4, 44'h0, 44'h0, acc);
      do_req(1'b0, 6'd5, 44'h0, 44'h0, acc);
      check("t6_pre_vld", lsu_if.rsp_vld, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_vld", lsu_if.rsp_vld, 0);
      check("t6_rdy", lsu_if.req_rdy, 0);
      check("t6_init_a0", {ram_cen, ram_gwen, ram_a}, {1'b0, 1'b0, 6'd0});
      lsu_if.rsp_rdy = 1'b1;
      base = rsp_log.size();
      n = 0;
      while (!init_done && n < 100) begin n++; @(negedge clk); end
      check("t6_reinit_len", n, 64);
      repeat (10) @(negedge clk);
      check("t6_no_stale", rsp_log.size() - base, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
